// File: rtl/seq_detector_pkg.sv
// Shared helpers for the serial pattern detector: state-width sizing and the
// KMP next-state function that builds the transition table at elaboration.
package seq_det_pkg;

    localparam int MAX_PAT_W = 16;

    function automatic int state_w(input int pat_w);
        int w;
        w = 1;
        for (int i = 5; i >= 1; i--) begin
            if ((1 << i) >= pat_w + 1) w = i;
        end
        return w;
    endfunction

    // Length of the longest proper prefix of the pattern that is also its suffix.
    function automatic int border(input logic [MAX_PAT_W-1:0] pattern, input int pat_w);
        int  best;
        logic ok;
        best = 0;
        for (int k = 1; k < MAX_PAT_W; k++) begin
            if (k < pat_w) begin
                ok = 1'b1;
                for (int i = 0; i < MAX_PAT_W; i++) begin
                    if (i < k && pattern[pat_w-1-i] != pattern[k-1-i]) ok = 1'b0;
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

    // Longest pattern prefix that is a suffix of (matched prefix, bit_in).
    function automatic int kmp_next(input logic [MAX_PAT_W-1:0] pattern, input int pat_w,
                                    input int state, input int bit_in, input bit overlap);
        int   s;
        int   j;
        int   best;
        logic ok;
        logic sb;
        if (state == pat_w) s = overlap ? border(pattern, pat_w) : 0;
        else                s = state;
        best = 0;
        for (int k = 1; k <= MAX_PAT_W; k++) begin
            if (k <= s + 1 && k <= pat_w) begin
                ok = 1'b1;
                for (int i = 0; i < MAX_PAT_W; i++) begin
                    if (i < k) begin
                        j  = s + 1 - k + i;
                        sb = (j < s) ? pattern[pat_w-1-j] : (bit_in != 0);
                        if (sb != pattern[pat_w-1-i]) ok = 1'b0;
                    end
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_detector_if.sv
// Serial-input and status bundle of the pattern detector.
interface seq_detector_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic                           en;
    logic                           a;
    logic                           clr;
    logic                           z;
    logic [CNT_W-1:0]               cnt;
    logic [$clog2(PAT_W+1)-1:0]     st;

    modport master (output en, output a, output clr, input z, input cnt, input st);
    modport slave  (input en, input a, input clr, output z, output cnt, output st);
endinterface

// File: rtl/seq_detector_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    localparam logic [W-1:0] MAX = '1;

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (v == MAX) ? MAX : v + W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     q <= '0;
        else if (clr) q <= '0;
        else if (inc) q <= sat_inc(q);
    end
endmodule

// File: rtl/seq_detector.sv
// Parametrised serial pattern detector: KMP state machine with an
// elaboration-time transition table, registered match pulse and match count.
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int             PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input logic           clk,
    input logic           rst,
    seq_detector_if.slave bus
);
    localparam int             SW   = state_w(PAT_W);
    localparam logic [SW-1:0]  LAST = SW'(PAT_W);

    logic [SW-1:0] nxt_tbl [PAT_W+1][2];
    logic [SW-1:0] st_p1;
    logic [SW-1:0] st_nxt_p0;
    logic          hit_p0;
    logic          z_p1;

    for (genvar s = 0; s <= PAT_W; s++) begin : g_st
        for (genvar b = 0; b < 2; b++) begin : g_bit
            assign nxt_tbl[s][b] = SW'(kmp_next(MAX_PAT_W'(PATTERN), PAT_W, s, b, OVERLAP));
        end
    end

    // p0: table lookup on the current state and incoming bit
    always_comb begin
        st_nxt_p0 = '0;
        if (st_p1 <= LAST) st_nxt_p0 = nxt_tbl[st_p1][bus.a];
        hit_p0 = bus.en && (st_nxt_p0 == LAST);
    end

    // p1: state, pulse and count registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_p1 <= '0;
            z_p1  <= 1'b0;
        end else begin
            z_p1 <= hit_p0;
            if (bus.en) st_p1 <= st_nxt_p0;
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.clr),
        .inc (hit_p0),
        .q   (bus.cnt)
    );

    assign bus.z  = z_p1;
    assign bus.st = st_p1;
endmodule

// File: tb/tb_seq_detector.sv
// Bench for seq_detector: three configurations share one input stream and are
// checked against hand tables, directed corner sequences and a history model.
module tb_seq_detector;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic en  = 1'b0;
    logic a   = 1'b0;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    seq_detector_if #(.PAT_W(4), .CNT_W(8)) ifa ();
    seq_detector_if #(.PAT_W(4), .CNT_W(8)) ifb ();
    seq_detector_if #(.PAT_W(2), .CNT_W(2)) ifc ();

    assign ifa.en = en; assign ifa.a = a; assign ifa.clr = clr;
    assign ifb.en = en; assign ifb.a = a; assign ifb.clr = clr;
    assign ifc.en = en; assign ifc.a = a; assign ifc.clr = clr;

    seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8))
        u_a (.clk(clk), .rst(rst), .bus(ifa));
    seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8))
        u_b (.clk(clk), .rst(rst), .bus(ifb));
    seq_detector #(.PAT_W(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2))
        u_c (.clk(clk), .rst(rst), .bus(ifc));

    int n_vec = 0;
    int n_err = 0;

    // Reference model: bit history since the last restart, matched by suffix search.
    int        m_pw  [3] = '{4, 4, 2};
    bit [15:0] m_pat [3] = '{16'h000B, 16'h000B, 16'h0003};
    bit        m_ov  [3] = '{1'b1, 1'b0, 1'b1};
    int        m_max [3] = '{255, 255, 3};
    bit [15:0] m_hv  [3];
    int        m_hn  [3];
    int        m_z   [3];
    int        m_cnt [3];
    int        m_st  [3];

    function automatic int longest(input bit [15:0] hv, input int hn,
                                   input bit [15:0] pat, input int pw);
        int best;
        bit ok;
        best = 0;
        for (int k = 1; k <= pw; k++) begin
            ok = (k <= hn);
            for (int i = 0; i < k; i++)
                if (hv[k-1-i] != pat[pw-1-i]) ok = 1'b0;
            if (ok) best = k;
        end
        return best;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_hv[i] = '0; m_hn[i] = 0; m_z[i] = 0; m_cnt[i] = 0; m_st[i] = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 3; i++) begin
            m_z[i] = 0;
            if (en) begin
                m_hv[i] = {m_hv[i][14:0], a};
                if (m_hn[i] < 16) m_hn[i]++;
                m_st[i] = longest(m_hv[i], m_hn[i], m_pat[i], m_pw[i]);
                if (m_st[i] == m_pw[i]) begin
                    m_z[i] = 1;
                    if (!m_ov[i]) m_hn[i] = 0;
                end
            end
            if (clr) m_cnt[i] = 0;
            else if (m_z[i] == 1 && m_cnt[i] < m_max[i]) m_cnt[i]++;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_z_a"},   ifa.z,   m_z[0]);
        chk({tag, "_cnt_a"}, ifa.cnt, m_cnt[0]);
        chk({tag, "_st_a"},  ifa.st,  m_st[0]);
        chk({tag, "_z_b"},   ifb.z,   m_z[1]);
        chk({tag, "_cnt_b"}, ifb.cnt, m_cnt[1]);
        chk({tag, "_st_b"},  ifb.st,  m_st[1]);
        chk({tag, "_z_c"},   ifc.z,   m_z[2]);
        chk({tag, "_cnt_c"}, ifc.cnt, m_cnt[2]);
        chk({tag, "_st_c"},  ifc.st,  m_st[2]);
    endtask

    task automatic step(input bit e, input bit d, input bit c, input string tag);
        @(negedge clk);
        en = e; a = d; clr = c;
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear before any edge.
    task automatic rst_pulse(input string tag);
        @(negedge clk);
        en = 1'b0; clr = 1'b0;
        rst = 1'b0;
        #1;
        chk({tag, "_async_z"},   ifa.z,   0);
        chk({tag, "_async_cnt"}, ifa.cnt, 0);
        chk({tag, "_async_st"},  ifa.st,  0);
        chk({tag, "_async_stb"}, ifb.st,  0);
        chk({tag, "_async_stc"}, ifc.st,  0);
        model_reset();
        #2;
        rst = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        check_all({tag, "_post"});
    endtask

    typedef struct {
        bit en, a, clr;
        bit za; int ca; int sa;
        bit zb; int cb; int sb;
    } vec_t;

    vec_t tbl [15];

    initial begin
        int zc;

        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1, 1'b0, 0, 1};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 2, 1'b0, 0, 2};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 3, 1'b0, 0, 3};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 4, 1'b1, 1, 4};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 2, 1'b0, 1, 0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 3, 1'b0, 1, 1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2, 4, 1'b0, 1, 1};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 2, 1'b0, 0, 2};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 3, 1'b0, 0, 3};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 0, 4, 1'b1, 0, 4};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 2, 1'b0, 0, 0};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 3, 1'b0, 0, 1};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 4, 1'b0, 0, 1};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 4, 1'b0, 0, 1};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 4, 1'b0, 0, 1};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // Stream 1011011, then clear and en-gap rows
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].en, tbl[i].a, tbl[i].clr, "tbl");
            chk("tbl_z_a",   ifa.z,   tbl[i].za);
            chk("tbl_cnt_a", ifa.cnt, tbl[i].ca);
            chk("tbl_st_a",  ifa.st,  tbl[i].sa);
            chk("tbl_z_b",   ifb.z,   tbl[i].zb);
            chk("tbl_cnt_b", ifb.cnt, tbl[i].cb);
            chk("tbl_st_b",  ifb.st,  tbl[i].sb);
        end

        // Enable gap: partial match held across five disabled edges
        rst_pulse("gap");
        step(1'b1, 1'b1, 1'b0, "gap");
        step(1'b1, 1'b0, 1'b0, "gap");
        step(1'b1, 1'b1, 1'b0, "gap");
        zc = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, i[0], 1'b0, "gap_hold");
            chk("gap_st_hold", ifa.st, 3);
            zc += ifa.z;
        end
        step(1'b1, 1'b1, 1'b0, "gap_resume");
        zc += ifa.z;
        chk("gap_z_pulses", zc, 1);
        chk("gap_cnt", ifa.cnt, 1);

        // Mid-stream reset discards the partial match
        rst_pulse("mid0");
        step(1'b1, 1'b1, 1'b0, "mid");
        step(1'b1, 1'b0, 1'b0, "mid");
        step(1'b1, 1'b1, 1'b0, "mid");
        rst_pulse("mid1");
        zc = 0;
        step(1'b1, 1'b1, 1'b0, "mid"); zc += ifa.z;
        step(1'b1, 1'b0, 1'b0, "mid"); zc += ifa.z;
        step(1'b1, 1'b1, 1'b0, "mid"); zc += ifa.z;
        step(1'b1, 1'b1, 1'b0, "mid"); zc += ifa.z;
        chk("mid_z_pulses", zc, 1);
        chk("mid_cnt", ifa.cnt, 1);

        // Pattern 11 back-to-back matches and 2-bit counter saturation
        rst_pulse("sat");
        zc = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b0, "sat");
            zc += ifc.z;
        end
        chk("sat_z_run", zc, 7);
        chk("sat_cnt_c", ifc.cnt, 3);

        // Random traffic against the model
        rst_pulse("rnd");
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 9) < 8), $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 39) == 0), "rnd");
            if (i % 400 == 399) rst_pulse("rnd_rst");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
